// File: rtl/mrd_bank_wrback.sv
// mrd_bank_wrback: write-back stage of the mixed-radix DFT memory.
// Scatters up to 5 butterfly result lanes into the 7 RAM bank write ports,
// counts beats per stage and pulses o_wr_end when the stage is written back.
// Optional check logic: define MRD_WR_CHECK_EN to enable o_err_flags
// (bit 0 bank conflict, bit 1 stray beat); otherwise o_err_flags is 2'b00.
module mrd_bank_wrback #(
    parameter int unsigned wADDR = 9,
    parameter int unsigned wDATA = 18,
    parameter int unsigned wCNT  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [wCNT-1:0]        i_wr_cnt_stop,
    input  logic                   i_in_valid,
    input  logic [0:4][2:0]        i_in_bank_index,
    input  logic [0:4][wADDR-1:0]  i_in_bank_addr,
    input  logic [0:4][wDATA-1:0]  i_in_d_real,
    input  logic [0:4][wDATA-1:0]  i_in_d_imag,
    output logic [0:6]             o_wren,
    output logic [0:6][wADDR-1:0]  o_wraddr,
    output logic [0:6][wDATA-1:0]  o_wrdata_real,
    output logic [0:6][wDATA-1:0]  o_wrdata_imag,
    output logic                   o_busy,
    output logic [wCNT-1:0]        o_cnt_wr,
    output logic                   o_wr_end,
    output logic [1:0]             o_err_flags
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]             r_state;
    logic [wCNT-1:0]        r_cnt;
    logic [wCNT-1:0]        r_stop;
    logic                   r_wr_end;
    logic [0:6]             r_wren;
    logic [0:6][wADDR-1:0]  r_wraddr;
    logic [0:6][wDATA-1:0]  r_wrdata_real;
    logic [0:6][wDATA-1:0]  r_wrdata_imag;

    logic                   w_accept;
    logic [wCNT-1:0]        w_cnt_inc;
    logic [0:6]             w_hit;
    logic [0:6][wADDR-1:0]  w_bank_addr;
    logic [0:6][wDATA-1:0]  w_bank_real;
    logic [0:6][wDATA-1:0]  w_bank_imag;

    // A coincident start takes precedence and drops the beat.
    assign w_accept  = (r_state == S_ARMED) && i_in_valid && !i_start;
    assign w_cnt_inc = r_cnt + wCNT'(1);

    // Per-bank lane select: first (lowest) lane targeting the bank wins.
    always_comb begin
        w_hit       = '0;
        w_bank_addr = '0;
        w_bank_real = '0;
        w_bank_imag = '0;
        for (int unsigned k = 0; k < 7; k++) begin
            for (int unsigned j = 0; j < 5; j++) begin
                if (!w_hit[k] && (i_in_bank_index[j] == k[2:0])) begin
                    w_hit[k]       = 1'b1;
                    w_bank_addr[k] = i_in_bank_addr[j];
                    w_bank_real[k] = i_in_d_real[j];
                    w_bank_imag[k] = i_in_d_imag[j];
                end
            end
        end
    end

    // Stage control: state, beat counter, stop value and end-of-stage pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_stop   <= '0;
            r_wr_end <= 1'b0;
        end else begin
            r_wr_end <= 1'b0;
            if (i_start) begin
                r_cnt  <= '0;
                r_stop <= i_wr_cnt_stop;
                if (i_wr_cnt_stop == '0) begin
                    r_state  <= S_DONE;
                    r_wr_end <= 1'b1;
                end else begin
                    r_state <= S_ARMED;
                end
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (i_in_valid) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == r_stop) begin
                                r_state  <= S_DONE;
                                r_wr_end <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Bank write ports: one-cycle enables, address/data held when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wren        <= '0;
            r_wraddr      <= '0;
            r_wrdata_real <= '0;
            r_wrdata_imag <= '0;
        end else begin
            for (int unsigned k = 0; k < 7; k++) begin
                r_wren[k] <= w_accept && w_hit[k];
                if (w_accept && w_hit[k]) begin
                    r_wraddr[k]      <= w_bank_addr[k];
                    r_wrdata_real[k] <= w_bank_real[k];
                    r_wrdata_imag[k] <= w_bank_imag[k];
                end
            end
        end
    end

`ifdef MRD_WR_CHECK_EN
    logic [1:0] r_err;
    logic       w_dup;
    logic       w_stray;

    // Two used lanes aimed at the same bank within one beat.
    always_comb begin
        w_dup = 1'b0;
        for (int unsigned j = 0; j < 4; j++) begin
            for (int unsigned m = j + 1; m < 5; m++) begin
                if ((i_in_bank_index[j] != 3'd7) &&
                    (i_in_bank_index[j] == i_in_bank_index[m])) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    assign w_stray = i_in_valid && (r_state != S_ARMED);

    // Sticky error flags, cleared by start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (i_start) begin
            r_err <= '0;
        end else begin
            if (w_accept && w_dup) r_err[0] <= 1'b1;
            if (w_stray)           r_err[1] <= 1'b1;
        end
    end

    assign o_err_flags = r_err;
`else
    assign o_err_flags = 2'b00;
`endif

    assign o_wren        = r_wren;
    assign o_wraddr      = r_wraddr;
    assign o_wrdata_real = r_wrdata_real;
    assign o_wrdata_imag = r_wrdata_imag;
    assign o_busy        = (r_state == S_ARMED);
    assign o_cnt_wr      = r_cnt;
    assign o_wr_end      = r_wr_end;

endmodule

// File: tb/tb_mrd_bank_wrback.sv
// tb_mrd_bank_wrback: directed vector table, hand sequences for restart and
// mid-stage reset, then randomized stimulus against a behavioural model.
module tb_mrd_bank_wrback;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [11:0]         stop;
    logic                valid;
    logic [0:4][2:0]     idx;
    logic [0:4][8:0]     addr;
    logic [0:4][17:0]    dr;
    logic [0:4][17:0]    di;
    logic [0:6]          wren;
    logic [0:6][8:0]     wraddr;
    logic [0:6][17:0]    wrreal;
    logic [0:6][17:0]    wrimag;
    logic                busy;
    logic [11:0]         cnt_wr;
    logic                wr_end;
    logic [1:0]          err;

    int n_vec = 0;
    int n_err = 0;

`ifdef MRD_WR_CHECK_EN
    localparam logic [1:0] ERR_MASK = 2'b11;
`else
    localparam logic [1:0] ERR_MASK = 2'b00;
`endif

    localparam logic [14:0] NONE = {5{3'd7}};
    localparam logic [14:0] T1   = {3'd0, 3'd1, 3'd2, 3'd7, 3'd7};
    localparam logic [14:0] R5   = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
    localparam logic [14:0] DUP  = {3'd3, 3'd3, 3'd7, 3'd7, 3'd7};

    mrd_bank_wrback #(.wADDR(9), .wDATA(18), .wCNT(12)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .i_wr_cnt_stop   (stop),
        .i_in_valid      (valid),
        .i_in_bank_index (idx),
        .i_in_bank_addr  (addr),
        .i_in_d_real     (dr),
        .i_in_d_imag     (di),
        .o_wren          (wren),
        .o_wraddr        (wraddr),
        .o_wrdata_real   (wrreal),
        .o_wrdata_imag   (wrimag),
        .o_busy          (busy),
        .o_cnt_wr        (cnt_wr),
        .o_wr_end        (wr_end),
        .o_err_flags     (err)
    );

    always #5 clk = ~clk;

    // One directed cycle: inputs (lane j: addr a0+j, real d0+100*j) and
    // the outputs expected after the edge; cb<0 skips the bank check.
    typedef struct {
        logic        st;
        logic [11:0] sp;
        logic        v;
        logic [14:0] ix;
        logic [8:0]  a0;
        logic [17:0] d0;
        logic [6:0]  ew;
        logic        eb;
        logic [11:0] ec;
        logic        ee;
        logic [1:0]  eerr;
        int          cb;
        logic [8:0]  ca;
        logic [17:0] cd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic [11:0] sp, input logic v,
                                input logic [14:0] ix, input logic [8:0] a0, input logic [17:0] d0,
                                input logic [6:0] ew, input logic eb, input logic [11:0] ec,
                                input logic ee, input logic [1:0] eerr, input int cb,
                                input logic [8:0] ca, input logic [17:0] cd);
        vec_t r;
        r.st = st; r.sp = sp; r.v = v; r.ix = ix; r.a0 = a0; r.d0 = d0;
        r.ew = ew; r.eb = eb; r.ec = ec; r.ee = ee; r.eerr = eerr;
        r.cb = cb; r.ca = ca; r.cd = cd;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic rv, input string tag);
        @(negedge clk);
        rst_n = rv;
        start = v.st;
        stop  = v.sp;
        valid = v.v;
        idx   = v.ix;
        for (int unsigned j = 0; j < 5; j++) begin
            addr[j] = v.a0 + 9'(j);
            dr[j]   = v.d0 + 18'(100 * j);
            di[j]   = ~dr[j];
        end
        @(posedge clk);
        #1;
        check({tag, ".wren"},   64'(wren),   64'(v.ew));
        check({tag, ".busy"},   64'(busy),   64'(v.eb));
        check({tag, ".cnt_wr"}, 64'(cnt_wr), 64'(v.ec));
        check({tag, ".wr_end"}, 64'(wr_end), 64'(v.ee));
        check({tag, ".err"},    64'(err),    64'(v.eerr & ERR_MASK));
        if (v.cb >= 0) begin
            check({tag, ".wraddr"}, 64'(wraddr[v.cb]), 64'(v.ca));
            check({tag, ".wrreal"}, 64'(wrreal[v.cb]), 64'(v.cd));
        end
    endtask

    // Behavioural reference: stage phase, beat count and last-written bank image.
    int          m_st;     // 0 idle, 1 armed, 2 done
    int          m_cnt;
    int          m_stop;
    bit          m_end;
    logic [1:0]  m_err;
    bit          m_wren [7];
    logic [8:0]  m_addr [7];
    logic [17:0] m_dr   [7];
    logic [17:0] m_di   [7];

    task automatic model_step();
        bit acc;
        bit stray;
        bit dup;
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_stop = 0; m_end = 0; m_err = 2'b00;
            for (int k = 0; k < 7; k++) begin
                m_wren[k] = 0; m_addr[k] = '0; m_dr[k] = '0; m_di[k] = '0;
            end
            return;
        end
        acc   = (m_st == 1) && valid && !start;
        stray = valid && (m_st != 1);
        dup   = 0;
        for (int k = 0; k < 7; k++) m_wren[k] = 0;
        if (acc) begin
            // highest lane first so the lowest lane's write lands last
            for (int j = 4; j >= 0; j--) begin
                if (idx[j] != 3'd7) begin
                    m_wren[idx[j]] = 1;
                    m_addr[idx[j]] = addr[j];
                    m_dr[idx[j]]   = dr[j];
                    m_di[idx[j]]   = di[j];
                end
            end
            for (int j = 0; j < 5; j++)
                for (int m = j + 1; m < 5; m++)
                    if (idx[j] != 3'd7 && idx[j] == idx[m]) dup = 1;
        end
        m_end = 0;
        if (start) begin
            m_cnt  = 0;
            m_stop = int'(stop);
            if (m_stop == 0) begin m_st = 2; m_end = 1; end
            else m_st = 1;
            m_err = 2'b00;
        end else begin
            if (acc) begin
                m_cnt++;
                if (m_cnt == m_stop) begin m_st = 2; m_end = 1; end
            end else if (m_st == 2) begin
                m_st = 0;
            end
            if (stray) m_err[1] = 1'b1;
            if (dup)   m_err[0] = 1'b1;
        end
    endtask

    initial begin
        vec_t z;
        logic [0:6] ew;
        rst_n = 1'b0; start = 1'b0; stop = '0; valid = 1'b0;
        idx = NONE; addr = '0; dr = '0; di = '0;

        z = mk(0, 0, 0, NONE, 0, 0, 7'b0, 0, 0, 0, 2'b00, 0, 0, 0);
        apply(z, 1'b0, "rst0");
        apply(z, 1'b0, "rst1");

        //           st sp v  idx   a0  d0   ew          eb ec ee err    cb ca  cd
        tbl.push_back(mk(0, 0, 0, NONE, 0,  0,   7'b0000000, 0, 0, 0, 2'b00, 0, 0,  0));
        tbl.push_back(mk(0, 0, 1, T1,   50, 9,   7'b0000000, 0, 0, 0, 2'b10, 0, 0,  0));
        tbl.push_back(mk(1, 3, 0, NONE, 0,  0,   7'b0000000, 1, 0, 0, 2'b00, -1, 0, 0));
        tbl.push_back(mk(0, 0, 1, T1,   5,  1,   7'b1110000, 1, 1, 0, 2'b00, 0, 5,  1));
        tbl.push_back(mk(0, 0, 1, T1,   5,  1,   7'b1110000, 1, 2, 0, 2'b00, 1, 6,  101));
        tbl.push_back(mk(0, 0, 1, T1,   5,  1,   7'b1110000, 0, 3, 1, 2'b00, 2, 7,  201));
        tbl.push_back(mk(0, 0, 0, NONE, 0,  0,   7'b0000000, 0, 3, 0, 2'b00, 2, 7,  201));
        tbl.push_back(mk(1, 1, 0, NONE, 0,  0,   7'b0000000, 1, 0, 0, 2'b00, -1, 0, 0));
        tbl.push_back(mk(0, 0, 1, R5,   10, 20,  7'b0011111, 0, 1, 1, 2'b00, 6, 10, 20));
        tbl.push_back(mk(0, 0, 0, NONE, 0,  0,   7'b0000000, 0, 1, 0, 2'b00, 2, 14, 420));
        tbl.push_back(mk(1, 2, 0, NONE, 0,  0,   7'b0000000, 1, 0, 0, 2'b00, -1, 0, 0));
        tbl.push_back(mk(0, 0, 1, DUP,  30, 100, 7'b0001000, 1, 1, 0, 2'b01, 3, 30, 100));
        tbl.push_back(mk(0, 0, 0, NONE, 0,  0,   7'b0000000, 1, 1, 0, 2'b01, 3, 30, 100));
        tbl.push_back(mk(0, 0, 1, NONE, 0,  0,   7'b0000000, 0, 2, 1, 2'b01, -1, 0, 0));
        tbl.push_back(mk(0, 0, 1, T1,   60, 3,   7'b0000000, 0, 2, 0, 2'b11, 0, 5,  1));
        tbl.push_back(mk(0, 0, 1, T1,   60, 3,   7'b0000000, 0, 2, 0, 2'b11, 0, 5,  1));
        tbl.push_back(mk(1, 0, 0, NONE, 0,  0,   7'b0000000, 0, 0, 1, 2'b00, -1, 0, 0));
        tbl.push_back(mk(0, 0, 0, NONE, 0,  0,   7'b0000000, 0, 0, 0, 2'b00, -1, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1, $sformatf("v%0d", i));

        // restart mid-stage at cnt_wr=2; the coincident beat is dropped
        apply(mk(1, 4, 0, NONE, 0,  0, 7'b0000000, 1, 0, 0, 2'b00, -1, 0, 0), 1'b1, "rs0");
        apply(mk(0, 0, 1, T1,   70, 5, 7'b1110000, 1, 1, 0, 2'b00, 0, 70, 5), 1'b1, "rs1");
        apply(mk(0, 0, 1, T1,   70, 5, 7'b1110000, 1, 2, 0, 2'b00, 0, 70, 5), 1'b1, "rs2");
        apply(mk(1, 4, 1, T1,   80, 6, 7'b0000000, 1, 0, 0, 2'b00, 0, 70, 5), 1'b1, "rs3");
        apply(mk(0, 0, 1, T1,   90, 5, 7'b1110000, 1, 1, 0, 2'b00, 0, 90, 5), 1'b1, "rs4");
        apply(mk(0, 0, 1, T1,   90, 5, 7'b1110000, 1, 2, 0, 2'b00, 0, 90, 5), 1'b1, "rs5");
        apply(mk(0, 0, 1, T1,   90, 5, 7'b1110000, 1, 3, 0, 2'b00, 0, 90, 5), 1'b1, "rs6");
        apply(mk(0, 0, 1, T1,   90, 5, 7'b1110000, 0, 4, 1, 2'b00, 0, 90, 5), 1'b1, "rs7");
        apply(mk(0, 0, 0, NONE, 0,  0, 7'b0000000, 0, 4, 0, 2'b00, 0, 90, 5), 1'b1, "rs8");

        // reset at beat 2 of 4, stray beat afterwards, then a clean stage
        apply(mk(1, 4, 0, NONE, 0,   0, 7'b0000000, 1, 0, 0, 2'b00, -1, 0, 0), 1'b1, "mr0");
        apply(mk(0, 0, 1, T1,   100, 7, 7'b1110000, 1, 1, 0, 2'b00, 0, 100, 7), 1'b1, "mr1");
        apply(mk(0, 0, 1, T1,   100, 7, 7'b0000000, 0, 0, 0, 2'b00, 0, 0,  0), 1'b0, "mr2");
        apply(mk(0, 0, 1, T1,   100, 7, 7'b0000000, 0, 0, 0, 2'b10, 0, 0,  0), 1'b1, "mr3");
        apply(mk(1, 4, 0, NONE, 0,   0, 7'b0000000, 1, 0, 0, 2'b00, 0, 0,  0), 1'b1, "mr4");
        apply(mk(0, 0, 1, T1,   110, 7, 7'b1110000, 1, 1, 0, 2'b00, 1, 111, 107), 1'b1, "mr5");
        apply(mk(0, 0, 1, T1,   110, 7, 7'b1110000, 1, 2, 0, 2'b00, 1, 111, 107), 1'b1, "mr6");
        apply(mk(0, 0, 1, T1,   110, 7, 7'b1110000, 1, 3, 0, 2'b00, 1, 111, 107), 1'b1, "mr7");
        apply(mk(0, 0, 1, T1,   110, 7, 7'b1110000, 0, 4, 1, 2'b00, 1, 111, 107), 1'b1, "mr8");

        // randomized phase against the reference model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 15) == 0);
            stop  = 12'($urandom_range(0, 6));
            valid = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 5; j++) begin
                idx[j]  = 3'($urandom_range(0, 7));
                addr[j] = 9'($urandom);
                dr[j]   = 18'($urandom);
                di[j]   = 18'($urandom);
            end
            model_step();
            @(posedge clk);
            #1;
            for (int k = 0; k < 7; k++) ew[k] = m_wren[k];
            check("rnd.wren",   64'(wren),   64'(ew));
            check("rnd.busy",   64'(busy),   64'(m_st == 1));
            check("rnd.cnt_wr", 64'(cnt_wr), 64'(m_cnt));
            check("rnd.wr_end", 64'(wr_end), 64'(m_end));
            check("rnd.err",    64'(err),    64'(m_err & ERR_MASK));
            for (int k = 0; k < 7; k++) begin
                check($sformatf("rnd.wraddr%0d", k), 64'(wraddr[k]), 64'(m_addr[k]));
                check($sformatf("rnd.wrreal%0d", k), 64'(wrreal[k]), 64'(m_dr[k]));
                check($sformatf("rnd.wrimag%0d", k), 64'(wrimag[k]), 64'(m_di[k]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
